// File: rtl/dtfm_frame_ctrl_pkg.sv
// Shared types and widths for the frame sequencer slice.
package dtfm_frame_ctrl_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned EDGE_DEPTH = 3;
  localparam int unsigned ENTRY_W    = IDX_W + WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ctrlState_t;

endpackage

// File: rtl/dtfm_sync_fifo.sv
// Single-clock FIFO with registered storage; push and pop may coincide when full.
module dtfm_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             cClk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge cClk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[rdPtr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/dtfm_frame_ctrl.sv
// Frame sequencer: counts dClk bits/words between sync fronts, queues tagged
// words to the consumer and flags short-frame, overflow and stall errors.
module dtfm_frame_ctrl
  import dtfm_frame_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned TIMEOUT         = 4096
) (
  input  logic              cClk,
  input  logic              reset,
  input  logic              dClk,
  input  logic              sync,
  input  logic [WORD_W-1:0] rxWord,
  input  logic              clrErr,
  output logic [WORD_W-1:0] wordOut,
  output logic [IDX_W-1:0]  wordIdx,
  output logic              wordValid,
  input  logic              wordReady,
  output logic              frameDone,
  output logic              errShort,
  output logic              errOverflow,
  output logic              errTimeout,
  output logic              busy
);

  localparam int unsigned     TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [EDGE_DEPTH-1:0] clkSr;
  logic [EDGE_DEPTH-1:0] syncSr;
  logic                  clkRear;
  logic                  syncFront;
  ctrlState_t            state;
  ctrlState_t            nextState;
  logic [3:0]            bitCnt;
  logic [IDX_W-1:0]      wordCnt;
  logic [IDX_W-1:0]      capWordCnt;
  logic [TMR_W-1:0]      timer;
  logic                  capPend;
  logic                  inRecv;
  logic                  lastWord;
  logic                  timeoutHit;
  logic                  popHead;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [ENTRY_W-1:0]    headData;

  always_ff @(posedge cClk) begin
    if (reset) begin
      clkSr  <= '0;
      syncSr <= '0;
    end else begin
      clkSr  <= {clkSr[EDGE_DEPTH-2:0], dClk};
      syncSr <= {syncSr[EDGE_DEPTH-2:0], sync};
    end
  end

  assign syncFront = !syncSr[EDGE_DEPTH-1] && syncSr[EDGE_DEPTH-2];
  assign clkRear   = clkSr[EDGE_DEPTH-1] && !clkSr[EDGE_DEPTH-2];

  assign inRecv     = (state == RECV);
  assign lastWord   = (wordCnt == LAST_IDX);
  assign capWordCnt = lastWord ? '0 : wordCnt + 1'b1;
  assign timeoutHit = inRecv && !clkRear && !syncFront && (timer == TMR_LAST);
  assign popHead    = wordValid && wordReady;

  always_ff @(posedge cClk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (syncFront) nextState = RECV;
      RECV: begin
        if (syncFront)                nextState = RECV;
        else if (capPend && lastWord) nextState = IDLE;
        else if (timeoutHit)          nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECV);
  end

  always_ff @(posedge cClk) begin
    if (reset) begin
      bitCnt    <= '0;
      wordCnt   <= '0;
      timer     <= '0;
      capPend   <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      capPend   <= inRecv && clkRear && !syncFront && (bitCnt == 4'd15);
      frameDone <= capPend && lastWord;
      if (syncFront || (inRecv && nextState == IDLE)) begin
        bitCnt  <= '0;
        wordCnt <= '0;
        timer   <= '0;
      end else if (inRecv) begin
        if (clkRear) begin
          bitCnt <= bitCnt + 1'b1;
          timer  <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
        if (capPend) begin
          wordCnt <= capWordCnt;
        end
      end
    end
  end

  // A front landing on the capture cycle judges the frame by the post-capture count.
  always_ff @(posedge cClk) begin
    if (reset) begin
      errShort    <= 1'b0;
      errOverflow <= 1'b0;
      errTimeout  <= 1'b0;
    end else begin
      if (inRecv && syncFront &&
          (bitCnt != '0 || (capPend ? capWordCnt : wordCnt) != '0)) errShort <= 1'b1;
      else if (clrErr) errShort <= 1'b0;

      if (capPend && fifoFull && !popHead) errOverflow <= 1'b1;
      else if (clrErr)                     errOverflow <= 1'b0;

      if (timeoutHit)  errTimeout <= 1'b1;
      else if (clrErr) errTimeout <= 1'b0;
    end
  end

  dtfm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .cClk     (cClk),
    .reset    (reset),
    .push     (capPend),
    .pushData ({wordCnt, rxWord}),
    .pop      (popHead),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign wordValid = !fifoEmpty;
  assign wordIdx   = headData[ENTRY_W-1:WORD_W];
  assign wordOut   = headData[WORD_W-1:0];

endmodule

// File: tb/tb_dtfm_frame_ctrl.sv
// Directed bench for dtfm_frame_ctrl with a queue-based output scoreboard.
module tb_dtfm_frame_ctrl;

  localparam int unsigned WPF   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 4096;

  logic        cClk = 1'b0;
  logic        reset = 1'b1;
  logic        dClk = 1'b1;
  logic        sync = 1'b0;
  logic [15:0] rxWord = '0;
  logic        clrErr = 1'b0;
  logic        wordReady = 1'b0;
  logic [15:0] wordOut;
  logic [7:0]  wordIdx;
  logic        wordValid;
  logic        frameDone;
  logic        errShort;
  logic        errOverflow;
  logic        errTimeout;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;
  int fdCount = 0;
  logic [23:0] expQ[$];
  logic [23:0] expEntry;

  always #5 cClk = ~cClk;

  dtfm_frame_ctrl #(
    .WORDS_PER_FRAME (WPF),
    .FIFO_DEPTH      (DEPTH),
    .TIMEOUT         (TMO)
  ) dut (
    .cClk        (cClk),
    .reset       (reset),
    .dClk        (dClk),
    .sync        (sync),
    .rxWord      (rxWord),
    .clrErr      (clrErr),
    .wordOut     (wordOut),
    .wordIdx     (wordIdx),
    .wordValid   (wordValid),
    .wordReady   (wordReady),
    .frameDone   (frameDone),
    .errShort    (errShort),
    .errOverflow (errOverflow),
    .errTimeout  (errTimeout),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted head entry is matched against the queue.
  always @(negedge cClk) begin
    #1;
    if (!reset) begin
      if (frameDone) fdCount++;
      if (wordValid && wordReady) begin
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("FAIL scoreboard: got idx=%0d word=0x%0h expected no entry", wordIdx, wordOut);
        end else begin
          expEntry = expQ.pop_front();
          if ({wordIdx, wordOut} !== expEntry) begin
            nFails++;
            $display("FAIL scoreboard: got idx=%0d word=0x%0h expected idx=%0d word=0x%0h",
                     wordIdx, wordOut, expEntry[23:16], expEntry[15:0]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cClk);
  endtask

  task automatic doReset();
    reset  = 1'b1;
    dClk   = 1'b1;
    sync   = 1'b0;
    clrErr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic sendSync();
    sync = 1'b1;
    tick(4);
    sync = 1'b0;
    tick(4);
  endtask

  task automatic pulseClr();
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
  endtask

  // LSB-first bits; rxWord mimics the receiver's shift register on each fall.
  task automatic sendBits(input logic [15:0] w, input int nBits, input bit syncAtCap);
    for (int i = 0; i < nBits; i++) begin
      dClk   = 1'b0;
      rxWord = {w[i], rxWord[15:1]};
      if (syncAtCap && i == nBits - 1) begin
        tick(1);
        sync = 1'b1;
        tick(3);
      end else begin
        tick(4);
      end
      dClk = 1'b1;
      tick(4);
    end
    if (syncAtCap) sync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    int lat;
    int wt;

    // Reset state and single-word capture latency
    doReset();
    check("reset outputs", {wordValid, wordOut, wordIdx, frameDone,
                            errShort, errOverflow, errTimeout, busy}, 32'd0);
    wordReady = 1'b0;
    sendSync();
    check("busy after sync", busy, 1);
    w = 16'hA5C3;
    expQ.push_back({8'd0, w});
    sendBits(w, 15, 1'b0);
    dClk   = 1'b0;
    rxWord = {w[15], rxWord[15:1]};
    lat = 0;
    while (!wordValid && lat < 20) begin
      tick(1);
      lat++;
    end
    check("capture latency", lat, 4);
    check("head before pop", {wordIdx, wordOut}, {8'd0, 16'hA5C3});
    dClk = 1'b1;
    tick(4);
    wordReady = 1'b1;
    tick(4);
    check("t1 drained", expQ.size(), 0);

    // Full frame of 4 words
    doReset();
    fdCount   = 0;
    wordReady = 1'b1;
    sendSync();
    for (int k = 1; k <= 4; k++) begin
      expQ.push_back({8'(k - 1), 16'(k)});
      sendBits(16'(k), 16, 1'b0);
    end
    tick(10);
    check("frameDone pulses", fdCount, 1);
    check("busy after frame", busy, 0);
    check("no errors frame", {errShort, errOverflow, errTimeout}, 0);
    check("t2 drained", expQ.size(), 0);

    // Overflow: four retained, two dropped
    doReset();
    wordReady = 1'b0;
    sendSync();
    for (int k = 0; k < 4; k++) begin
      expQ.push_back({8'(k), 16'(16'h1001 + k)});
      sendBits(16'(16'h1001 + k), 16, 1'b0);
    end
    check("idle after frame", busy, 0);
    sendSync();
    sendBits(16'h1005, 16, 1'b0);
    sendBits(16'h1006, 16, 1'b0);
    tick(4);
    check("errOverflow set", errOverflow, 1);
    check("fifo holds data", wordValid, 1);
    pulseClr();
    check("errOverflow cleared", errOverflow, 0);
    wordReady = 1'b1;
    tick(8);
    check("t3 drained", expQ.size(), 0);

    // Short word: sync after 7 bits of the third word
    doReset();
    wordReady = 1'b1;
    sendSync();
    expQ.push_back({8'd0, 16'h1111});
    sendBits(16'h1111, 16, 1'b0);
    expQ.push_back({8'd1, 16'h2222});
    sendBits(16'h2222, 16, 1'b0);
    sendBits(16'h3333, 7, 1'b0);
    sendSync();
    check("errShort mid-word", errShort, 1);
    check("busy after restart", busy, 1);
    expQ.push_back({8'd0, 16'h4444});
    sendBits(16'h4444, 16, 1'b0);
    tick(6);
    check("t4 drained", expQ.size(), 0);

    // dClk stall timeout
    doReset();
    wordReady = 1'b1;
    fdCount   = 0;
    sync = 1'b1;
    tick(4);
    sync = 1'b0;
    tick(3990);
    check("no early timeout", errTimeout, 0);
    check("busy before timeout", busy, 1);
    wt = 0;
    while (!errTimeout && wt < 300) begin
      tick(1);
      wt++;
    end
    check("timeout cycle", wt, 105);
    check("errTimeout set", errTimeout, 1);
    check("busy after timeout", busy, 0);
    check("no frameDone on timeout", fdCount, 0);
    pulseClr();
    check("errTimeout cleared", errTimeout, 0);
    sendSync();
    expQ.push_back({8'd0, 16'h5A5A});
    sendBits(16'h5A5A, 16, 1'b0);
    tick(6);
    check("t5 drained", expQ.size(), 0);

    // Sync front in the capture cycle of word 0, then reset mid-frame
    doReset();
    wordReady = 1'b1;
    sendSync();
    expQ.push_back({8'd0, 16'hBEEF});
    sendBits(16'hBEEF, 16, 1'b1);
    check("errShort at capture", errShort, 1);
    check("busy after capture restart", busy, 1);
    tick(4);
    check("t6 drained", expQ.size(), 0);
    wordReady = 1'b0;
    sendBits(16'h7777, 16, 1'b0);
    sendBits(16'h00FF, 3, 1'b0);
    check("fifo loaded before reset", wordValid, 1);
    reset = 1'b1;
    tick(1);
    check("outputs after reset", {wordValid, wordOut, wordIdx, frameDone,
                                  errShort, errOverflow, errTimeout, busy}, 32'd0);
    reset = 1'b0;
    expQ.delete();
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dtfm_frame_ctrl.md
Name: dtfm_frame_ctrl

Overview:
Frame-level sequencer for the 16-bit serial word receiver. It tracks the same dClk/sync line as the receiver and counts bits and words within a frame. On each completed word it captures the receiver's parallel word, tags it with its index, and queues it to the downstream consumer through a valid/ready FIFO. It also reports frame completion and framing errors: short word/frame, FIFO overflow and dClk timeout.

Parameters:
WORDS_PER_FRAME, 32, words per frame between sync fronts (2..255)
FIFO_DEPTH, 4, output queue entries (power of 2, >=2)
TIMEOUT, 4096, max cClk cycles without a dClk rear edge while in RECV

Ports:
cClk  in  1  common clock
reset  in  1  synchronous, active-high reset
dClk  in  1  raw incoming data clock (same net as receiver)
sync  in  1  raw frame marker (same net as receiver)
rxWord  in  16  parallel word from receiver
clrErr  in  1  clears sticky error flags
wordOut  out  16  queued word, FIFO head
wordIdx  out  8  word index within frame, 0-based, FIFO head
wordValid  out  1  FIFO non-empty
wordReady  in  1  consumer accepts head when wordValid=1
frameDone  out  1  one-cycle pulse after last word of frame is captured
errShort  out  1  sticky: sync front arrived mid-word or mid-frame
errOverflow  out  1  sticky: captured word dropped, FIFO full
errTimeout  out  1  sticky: dClk stalled TIMEOUT cycles in RECV
busy  out  1  high in RECV

Behaviour:
- Edge detection: dClk and sync each pass a 3-stage shift register on cClk. syncFront = !s[2]&s[1]; clkRear = c[2]&!c[1]. This matches the receiver exactly, so edges align cycle-for-cycle.
- Reset, synchronous on cClk: state=IDLE; bitCnt, wordCnt, timer and FIFO cleared. Outputs: wordValid=0, wordOut=0, wordIdx=0, frameDone=0, all err*=0, busy=0. Sync registers are cleared to 0.
- States: IDLE, RECV.
- IDLE: clkRear is ignored. syncFront -> RECV with bitCnt=0, wordCnt=0, timer=0.
- RECV, each clkRear: bitCnt+1 (4-bit, wraps 15->0), timer=0.
- When clkRear occurs with bitCnt==15, capPend is set for exactly one cycle. On the following cycle rxWord is sampled; the receiver has written bit 15 by then.
- Capture cycle: push {wordCnt, rxWord}, then wordCnt+1. If this was word WORDS_PER_FRAME-1: pulse frameDone and go to IDLE.
- Capture with FIFO full and no simultaneous pop: the word is dropped and errOverflow is set. wordCnt still advances.
- Capture and pop in the same cycle on a full FIFO: both happen, no overflow.
- syncFront in RECV: restart the frame (bitCnt=0, wordCnt=0, timer=0, stay in RECV). If bitCnt!=0 or wordCnt!=0, set errShort.
- syncFront and clkRear in the same cycle: syncFront wins and the edge is not counted (matches the receiver clearing).
- syncFront in the capture cycle: the pending capture completes first and belongs to the old frame. The restart is then applied, with wordCnt reset after the increment, and the frameDone check is still applied.
- Timer increments every RECV cycle without clkRear. When it reaches TIMEOUT-1: set errTimeout and go to IDLE, with no frameDone.
- Pop: a FIFO entry is removed on cycles where wordValid & wordReady. The head is registered, so a capture into an empty FIFO shows wordValid=1 on the next cycle (2 cycles after the 16th clkRear).
- clrErr clears all sticky flags. A set condition in the same cycle wins over clrErr.
- wordIdx width is 8 bits; wordCnt compare uses WORDS_PER_FRAME-1.
- busy = (state==RECV).

Decomposition:
- Shared package/include holds:
  - state encoding (IDLE=0, RECV=1)
  - WORD_W=16, IDX_W=8
  - edge-detector depth 3
- One sub-module: dtfm_sync_fifo.
  - Parameterised width and depth; here width=24 ({idx,word}).
  - push/pop/full/empty ports; simultaneous push+pop allowed when full.
  - Synchronous active-high reset.

Test Plan:
- Reset then a sync front followed by 16 dClk periods with data pattern 0xA5C3 LSB first -> one entry wordOut=0xA5C3, wordIdx=0. wordValid rises 2 cClk after the 16th detected rear edge.
- WORDS_PER_FRAME=4: sync plus 64 bits carrying 0x0001..0x0004, wordReady=1 -> four entries with idx 0..3, frameDone pulses once after idx 3, busy=0, no errors.
- wordReady=0, FIFO_DEPTH=4, six words sent -> first four retained (idx 0..3), errOverflow=1. After a clrErr pulse the flag is 0 and draining yields 0..3 in order.
- Sync front after 7 bits of word 2 -> errShort=1, frame restarts. The next full word is queued with wordIdx=0.
- dClk held static for 4096 cClk in RECV -> errTimeout=1, busy=0, no frameDone. A later sync front resumes normal capture.
- Sync front in the capture cycle of word 0 -> word 0 is still queued with idx 0 and errShort=1 (wordCnt was 1). Reset asserted mid-frame -> all outputs are zero on the next cycle.
